// File: rtl/cc_frogger_pkg.sv
// Shared Frogger definitions.
// Provides the crash/lives FSM state type and the default 50 MHz tick counts
// used to size the hit freeze (1 s) and the blink half-period (125 ms).
package cc_frogger_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StHit,
    StGameover
  } state_e;

  localparam int unsigned TicksOneSec    = 50_000_000;
  localparam int unsigned TicksBlinkHalf = 6_250_000;

endpackage

// File: rtl/cc_crash_lives_fsm_if.sv
// Crash/lives bus between the Frogger game logic and cc_crash_lives_fsm.
// Signals:
//   CC_CRASHLIVES_crash_InLow      comparator crash flag, 0 = frog overlaps traffic
//   CC_CRASHLIVES_start_InHigh     start/restart request, level-sampled
//   CC_CRASHLIVES_lives_OutBUS     remaining lives
//   CC_CRASHLIVES_freeze_OutHigh   1 = traffic and frog movement halted
//   CC_CRASHLIVES_blink_OutHigh    frog blink enable
//   CC_CRASHLIVES_respawn_OutHigh  one-cycle respawn pulse
//   CC_CRASHLIVES_gameover_OutHigh 1 = game over
// Modports: master = game side (drives crash/start), slave = the FSM.
interface cc_crash_lives_fsm_if #(
  parameter int unsigned LIVES_WIDTH = 2
) ();

  logic                   CC_CRASHLIVES_crash_InLow;
  logic                   CC_CRASHLIVES_start_InHigh;
  logic [LIVES_WIDTH-1:0] CC_CRASHLIVES_lives_OutBUS;
  logic                   CC_CRASHLIVES_freeze_OutHigh;
  logic                   CC_CRASHLIVES_blink_OutHigh;
  logic                   CC_CRASHLIVES_respawn_OutHigh;
  logic                   CC_CRASHLIVES_gameover_OutHigh;

  modport master (
    output CC_CRASHLIVES_crash_InLow,
    output CC_CRASHLIVES_start_InHigh,
    input  CC_CRASHLIVES_lives_OutBUS,
    input  CC_CRASHLIVES_freeze_OutHigh,
    input  CC_CRASHLIVES_blink_OutHigh,
    input  CC_CRASHLIVES_respawn_OutHigh,
    input  CC_CRASHLIVES_gameover_OutHigh
  );

  modport slave (
    input  CC_CRASHLIVES_crash_InLow,
    input  CC_CRASHLIVES_start_InHigh,
    output CC_CRASHLIVES_lives_OutBUS,
    output CC_CRASHLIVES_freeze_OutHigh,
    output CC_CRASHLIVES_blink_OutHigh,
    output CC_CRASHLIVES_respawn_OutHigh,
    output CC_CRASHLIVES_gameover_OutHigh
  );

endinterface

// File: rtl/cc_crash_filter.sv
// Consecutive-low crash filter.
// Counts cycles with crash_ni low while enabled, saturating at CONFIRM_CYCLES;
// any high sample, a clear or a disable returns the count to 0.
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   en_i          count only while enabled (play)
//   clr_i         force count to 0 on the next edge
//   crash_ni      crash flag, active-low
//   hit_accept_o  high while the count sits at CONFIRM_CYCLES and enabled
module cc_crash_filter #(
  parameter int unsigned CONFIRM_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  input  logic crash_ni,
  output logic hit_accept_o
);

  localparam int unsigned CntWidth = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(CONFIRM_CYCLES);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i || crash_ni) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_accept_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/cc_crash_lives_fsm.sv
// Frogger crash / lives controller.
// Filters the comparator crash flag, decrements lives on an accepted hit,
// freezes play for HIT_CYCLES with a blinking frog, pulses respawn on return
// to play and holds game over once lives run out. All outputs are registered.
// Ports:
//   CC_CRASHLIVES_CLOCK_50      system clock, rising edge
//   CC_CRASHLIVES_RESET_InHigh  synchronous reset, active-high
//   bus (slave)                 crash/start in; lives/freeze/blink/respawn/gameover out
module cc_crash_lives_fsm
  import cc_frogger_pkg::*;
#(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned LIVES_WIDTH    = 2,
  parameter int unsigned CONFIRM_CYCLES = 4,
  parameter int unsigned HIT_CYCLES     = TicksOneSec,
  parameter int unsigned BLINK_HALF     = TicksBlinkHalf,
  parameter int unsigned TIMER_WIDTH    = 26
) (
  input logic                 CC_CRASHLIVES_CLOCK_50,
  input logic                 CC_CRASHLIVES_RESET_InHigh,
  cc_crash_lives_fsm_if.slave bus
);

  localparam logic [TIMER_WIDTH-1:0] HitLast   = TIMER_WIDTH'(HIT_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] BlinkLast = TIMER_WIDTH'(BLINK_HALF - 1);
  localparam logic [LIVES_WIDTH-1:0] LivesLoad = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LivesOne  = LIVES_WIDTH'(1);

  state_e state_q, state_d;

  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic                   freeze_q, freeze_d;
  logic                   blink_q, blink_d;
  logic                   respawn_q, respawn_d;
  logic                   gameover_q, gameover_d;
  logic [TIMER_WIDTH-1:0] hit_tmr_q, hit_tmr_d;
  logic [TIMER_WIDTH-1:0] blink_tmr_q, blink_tmr_d;

  logic hit_accept;
  logic hit_done;
  logic state_chg;
  logic stay_hit;

  assign hit_done  = (hit_tmr_q == HitLast);
  assign state_chg = (state_d != state_q);
  assign stay_hit  = (state_q == StHit) && (state_d == StHit);

  // Filter only runs in play and restarts from 0 on any state change.
  cc_crash_filter #(
    .CONFIRM_CYCLES(CONFIRM_CYCLES)
  ) u_filter (
    .clk_i       (CC_CRASHLIVES_CLOCK_50),
    .rst_i       (CC_CRASHLIVES_RESET_InHigh),
    .en_i        (state_q == StPlay),
    .clr_i       (state_chg),
    .crash_ni    (bus.CC_CRASHLIVES_crash_InLow),
    .hit_accept_o(hit_accept)
  );

  // State and registered outputs.
  always_ff @(posedge CC_CRASHLIVES_CLOCK_50) begin
    if (CC_CRASHLIVES_RESET_InHigh) begin
      state_q     <= StIdle;
      lives_q     <= '0;
      freeze_q    <= 1'b1;
      blink_q     <= 1'b0;
      respawn_q   <= 1'b0;
      gameover_q  <= 1'b0;
      hit_tmr_q   <= '0;
      blink_tmr_q <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      freeze_q    <= freeze_d;
      blink_q     <= blink_d;
      respawn_q   <= respawn_d;
      gameover_q  <= gameover_d;
      hit_tmr_q   <= hit_tmr_d;
      blink_tmr_q <= blink_tmr_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StGameover: begin
        if (bus.CC_CRASHLIVES_start_InHigh) state_d = StPlay;
      end
      StPlay: begin
        // Last life lost goes straight to game over, no freeze/respawn.
        if (hit_accept) state_d = (lives_q == LivesOne) ? StGameover : StHit;
      end
      StHit: begin
        if (hit_done) state_d = StPlay;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and timer next values, derived from the transition being taken.
  always_comb begin
    freeze_d    = (state_d != StPlay);
    gameover_d  = (state_d == StGameover);
    respawn_d   = (state_d == StPlay) && (state_q != StPlay);

    lives_d = lives_q;
    if ((state_q == StIdle || state_q == StGameover) && state_d == StPlay) begin
      lives_d = LivesLoad;
    end else if (hit_accept && lives_q != '0) begin
      lives_d = lives_q - 1'b1;
    end

    hit_tmr_d   = '0;
    blink_tmr_d = '0;
    if (stay_hit) begin
      hit_tmr_d   = hit_tmr_q + 1'b1;
      blink_tmr_d = (blink_tmr_q == BlinkLast) ? '0 : blink_tmr_q + 1'b1;
    end

    blink_d = 1'b0;
    if (state_d == StHit) begin
      if (state_q != StHit) begin
        blink_d = 1'b1;
      end else begin
        blink_d = (blink_tmr_q == BlinkLast) ? ~blink_q : blink_q;
      end
    end
  end

  assign bus.CC_CRASHLIVES_lives_OutBUS     = lives_q;
  assign bus.CC_CRASHLIVES_freeze_OutHigh   = freeze_q;
  assign bus.CC_CRASHLIVES_blink_OutHigh    = blink_q;
  assign bus.CC_CRASHLIVES_respawn_OutHigh  = respawn_q;
  assign bus.CC_CRASHLIVES_gameover_OutHigh = gameover_q;

endmodule

// File: tb/tb_cc_crash_lives_fsm.sv
// Bench for cc_crash_lives_fsm: table vectors, hand-written corner sequences
// and randomized crash/start/reset traffic against a behavioural model.
module tb_cc_crash_lives_fsm;

  localparam int unsigned LivesInit = 3;
  localparam int unsigned Confirm   = 4;
  localparam int unsigned HitCyc    = 20;
  localparam int unsigned BlinkHalf = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cc_crash_lives_fsm_if #(.LIVES_WIDTH(2)) bus ();

  cc_crash_lives_fsm #(
    .LIVES_INIT    (LivesInit),
    .LIVES_WIDTH   (2),
    .CONFIRM_CYCLES(Confirm),
    .HIT_CYCLES    (HitCyc),
    .BLINK_HALF    (BlinkHalf),
    .TIMER_WIDTH   (26)
  ) dut (
    .CC_CRASHLIVES_CLOCK_50    (clk),
    .CC_CRASHLIVES_RESET_InHigh(rst),
    .bus                       (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: game in progress / over flags, lives, remaining
  // freeze cycles and the current run of low crash samples.
  bit m_active = 1'b0;
  bit m_over   = 1'b0;
  bit m_resp   = 1'b0;
  int m_lives  = 0;
  int m_hit_left = 0;
  int m_low    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit cr);
    if (r) begin
      m_active = 1'b0; m_over = 1'b0; m_resp = 1'b0;
      m_lives = 0; m_hit_left = 0; m_low = 0;
      return;
    end
    m_resp = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_active = 1'b1; m_over = 1'b0; m_lives = LivesInit; m_low = 0; m_resp = 1'b1;
      end
    end else if (m_hit_left > 0) begin
      m_hit_left--;
      if (m_hit_left == 0) m_resp = 1'b1;
    end else if (m_low == Confirm) begin
      m_lives--;
      m_low = 0;
      if (m_lives == 0) begin
        m_active = 1'b0; m_over = 1'b1;
      end else begin
        m_hit_left = HitCyc;
      end
    end else begin
      m_low = cr ? 0 : ((m_low + 1 > Confirm) ? Confirm : m_low + 1);
    end
  endtask

  function automatic int m_blink();
    if (m_hit_left == 0) return 0;
    return (((HitCyc - m_hit_left) / BlinkHalf) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.CC_CRASHLIVES_start_InHigh, bus.CC_CRASHLIVES_crash_InLow);
    #1;
    check("model_lives", int'(bus.CC_CRASHLIVES_lives_OutBUS), m_lives);
    check("model_freeze", int'(bus.CC_CRASHLIVES_freeze_OutHigh),
          (!m_active || m_hit_left > 0) ? 1 : 0);
    check("model_blink", int'(bus.CC_CRASHLIVES_blink_OutHigh), m_blink());
    check("model_respawn", int'(bus.CC_CRASHLIVES_respawn_OutHigh), int'(m_resp));
    check("model_gameover", int'(bus.CC_CRASHLIVES_gameover_OutHigh), int'(m_over));
  endtask

  task automatic apply(input bit r, input bit st, input bit cr);
    rst = r;
    bus.CC_CRASHLIVES_start_InHigh = st;
    bus.CC_CRASHLIVES_crash_InLow  = cr;
    tick();
  endtask

  task automatic check_outs(input string tag, input int lv, input int fr, input int bl,
                            input int rs, input int go);
    check({tag, "_lives"}, int'(bus.CC_CRASHLIVES_lives_OutBUS), lv);
    check({tag, "_freeze"}, int'(bus.CC_CRASHLIVES_freeze_OutHigh), fr);
    check({tag, "_blink"}, int'(bus.CC_CRASHLIVES_blink_OutHigh), bl);
    check({tag, "_respawn"}, int'(bus.CC_CRASHLIVES_respawn_OutHigh), rs);
    check({tag, "_gameover"}, int'(bus.CC_CRASHLIVES_gameover_OutHigh), go);
  endtask

  typedef struct {
    bit rst;
    bit start;
    bit crash;
    int lives;
    int freeze;
    int blink;
    int resp;
    int go;
  } vec_t;

  vec_t vt[15];

  initial begin
    bit cr_val;
    int run_left;

    // rst start crash | lives freeze blink respawn gameover (after the edge)
    vt[0]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 0, 1, 0, 0, 0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 0, 1, 0, 0, 0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 3, 0, 0, 1, 0};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 3, 0, 0, 0, 0};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 3, 0, 0, 0, 0};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[9]  = '{1'b0, 1'b0, 1'b1, 3, 0, 0, 0, 0};
    vt[10] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[12] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[13] = '{1'b0, 1'b0, 1'b0, 3, 0, 0, 0, 0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 2, 1, 1, 0, 0};

    bus.CC_CRASHLIVES_start_InHigh = 1'b0;
    bus.CC_CRASHLIVES_crash_InLow  = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply(vt[i].rst, vt[i].start, vt[i].crash);
      check_outs($sformatf("vec%0d", i), vt[i].lives, vt[i].freeze, vt[i].blink,
                 vt[i].resp, vt[i].go);
    end

    // Freeze period with crash held low and start held high.
    for (int k = 1; k < int'(HitCyc); k++) begin
      apply(1'b0, 1'b1, 1'b0);
      check($sformatf("hit%0d_lives", k), int'(bus.CC_CRASHLIVES_lives_OutBUS), 2);
      check($sformatf("hit%0d_freeze", k), int'(bus.CC_CRASHLIVES_freeze_OutHigh), 1);
      if (k == 5)  check("hit5_blink", int'(bus.CC_CRASHLIVES_blink_OutHigh), 0);
      if (k == 10) check("hit10_blink", int'(bus.CC_CRASHLIVES_blink_OutHigh), 1);
      if (k == 19) check("hit19_blink", int'(bus.CC_CRASHLIVES_blink_OutHigh), 0);
    end
    apply(1'b0, 1'b1, 1'b0);
    check_outs("hit_exit", 2, 0, 0, 1, 0);
    apply(1'b0, 1'b1, 1'b1);
    check_outs("hit_exit_next", 2, 0, 0, 0, 0);

    // Run crash low until the last life is gone.
    for (int n = 0; n < 200 && !bus.CC_CRASHLIVES_gameover_OutHigh; n++) begin
      apply(1'b0, 1'b0, 1'b0);
    end
    check_outs("gameover", 0, 1, 0, 0, 1);
    apply(1'b0, 1'b1, 1'b1);
    check_outs("restart", 3, 0, 0, 1, 0);

    // Reset on the 10th cycle of a hit, with start and crash active.
    apply(1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 5; n++) apply(1'b0, 1'b0, 1'b0);
    check_outs("hit_entry2", 2, 1, 1, 0, 0);
    for (int n = 0; n < 9; n++) apply(1'b0, 1'b1, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    check_outs("mid_hit_reset", 0, 1, 0, 0, 0);
    apply(1'b0, 1'b0, 1'b1);
    check_outs("after_reset_idle", 0, 1, 0, 0, 0);

    // Randomized traffic: crash in runs, occasional start and rare reset.
    run_left = 0;
    cr_val = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      if (run_left == 0) begin
        run_left = int'($urandom_range(1, 7));
        cr_val = $urandom_range(0, 1) == 0;
      end
      run_left--;
      apply(($urandom_range(0, 399) == 0), ($urandom_range(0, 19) == 0), cr_val);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
